// File: rtl/pc_pkg.sv
// Shared program-counter definitions: op encoding and default widths used by
// pcounter_stack, decode and rom.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_JUMP = 3'd1,
    PC_CALL = 3'd2,
    PC_RET  = 3'd3,
    PC_SKIP = 3'd4,
    PC_HOLD = 3'd5
  } pc_op_t;

  localparam int unsigned PC_W_DEFAULT        = 11;
  localparam int unsigned STACK_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/pc_stack_lifo.sv
// Return-address LIFO with a circular pointer and a saturating occupancy count.
// Push when full overwrites the oldest slot; pop when empty reads the wrapped
// slot. Simultaneous push and pop replaces the top entry in place.
module pc_stack_lifo #(
  parameter int unsigned DATA_W      = 11,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic [DATA_W-1:0]                  i_data,
  output logic [DATA_W-1:0]                  o_data,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_depth,
  output logic                               o_full,
  output logic                               o_empty
);

  localparam int unsigned PtrW   = $clog2(STACK_DEPTH);
  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam logic [DepthW-1:0] FullCount = DepthW'(STACK_DEPTH);
  localparam logic [PtrW-1:0]   LastSlot  = PtrW'(STACK_DEPTH - 1);

  logic [DATA_W-1:0] r_mem [STACK_DEPTH];
  logic [PtrW-1:0]   r_ptr;     // next free slot
  logic [DepthW-1:0] r_depth;

  logic [PtrW-1:0]   w_ptr_p1;
  logic [PtrW-1:0]   w_ptr_m1;
  logic [PtrW-1:0]   w_ptr_nxt;
  logic [DepthW-1:0] w_depth_nxt;
  logic              w_we;
  logic [PtrW-1:0]   w_waddr;

  assign w_ptr_p1 = (r_ptr == LastSlot) ? '0 : r_ptr + 1'b1;
  assign w_ptr_m1 = (r_ptr == '0) ? LastSlot : r_ptr - 1'b1;

  assign o_data  = r_mem[w_ptr_m1];
  assign o_depth = r_depth;
  assign o_full  = (r_depth == FullCount);
  assign o_empty = (r_depth == '0);

  // Pointer, depth and write-port control for push/pop combinations.
  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_ptr_nxt   = r_ptr;
    w_depth_nxt = r_depth;
    if (i_push && i_pop) begin
      w_we    = 1'b1;
      w_waddr = w_ptr_m1;
    end else if (i_push) begin
      w_we      = 1'b1;
      w_ptr_nxt = w_ptr_p1;
      if (!o_full) w_depth_nxt = r_depth + 1'b1;
    end else if (i_pop) begin
      w_ptr_nxt = w_ptr_m1;
      if (!o_empty) w_depth_nxt = r_depth - 1'b1;
    end
  end

  // Pointer and depth state; the stack discards all entries on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_depth <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_depth <= w_depth_nxt;
    end
  end

  // Storage array; contents are don't-care after reset so it has no reset.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= i_data;
  end

endmodule

// File: rtl/pcounter_stack.sv
// Program counter with increment, jump, skip and call/return via an internal
// return-address stack. Macro PCSTACK_CHECK_EN selects checked mode (guarded
// push/pop with sticky ovf/unf flags); otherwise the stack is circular and the
// flags are tied to 0.
module pcounter_stack
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W         = PC_W_DEFAULT,
  parameter int unsigned     STACK_DEPTH  = STACK_DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [2:0]                        op,
  input  logic [PC_W-1:0]                   target,
  input  logic                              clr_flags,
  output logic [PC_W-1:0]                   counter,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
  output logic                              stack_full,
  output logic                              stack_empty,
  output logic                              stack_ovf,
  output logic                              stack_unf
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_skip;
  logic [PC_W-1:0] w_pop_data;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_pc_skip = r_pc + PC_W'(2);

  pc_stack_lifo #(
    .DATA_W      (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_lifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_pop_data),
    .o_depth (depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign counter     = r_pc;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

`ifdef PCSTACK_CHECK_EN
  logic w_set_ovf;
  logic w_set_unf;
  logic r_ovf;
  logic r_unf;

  // Next-PC mux; full-stack CALL and empty-stack RET are guarded and flagged.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (en) begin
      case (op)
        PC_JUMP: w_pc_nxt = target;
        PC_CALL: begin
          w_pc_nxt = target;
          if (w_full) w_set_ovf = 1'b1;
          else        w_push    = 1'b1;
        end
        PC_RET: begin
          if (w_empty) begin
            w_pc_nxt  = w_pc_inc;
            w_set_unf = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_pop_data;
          end
        end
        PC_SKIP: w_pc_nxt = w_pc_skip;
        PC_HOLD: w_pc_nxt = r_pc;
        default: w_pc_nxt = w_pc_inc;  // INC and reserved codes
      endcase
    end
  end

  // Sticky error flags; clear wins over a same-cycle set and ignores en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clr_flags) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;
`else
  logic w_unused_clr;

  // Next-PC mux; the stack wraps freely so CALL/RET are never guarded.
  always_comb begin
    w_pc_nxt = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (en) begin
      case (op)
        PC_JUMP: w_pc_nxt = target;
        PC_CALL: begin
          w_pc_nxt = target;
          w_push   = 1'b1;
        end
        PC_RET: begin
          w_pop    = 1'b1;
          w_pc_nxt = w_pop_data;
        end
        PC_SKIP: w_pc_nxt = w_pc_skip;
        PC_HOLD: w_pc_nxt = r_pc;
        default: w_pc_nxt = w_pc_inc;  // INC and reserved codes
      endcase
    end
  end

  assign w_unused_clr = clr_flags;
  assign stack_ovf    = 1'b0;
  assign stack_unf    = 1'b0;
`endif

  // Program-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pc <= RESET_VECTOR;
    else        r_pc <= w_pc_nxt;
  end

endmodule

// File: tb/tb_pcounter_stack.sv
// Directed self-checking bench for pcounter_stack (PC_W=11, STACK_DEPTH=8,
// RESET_VECTOR=0). Honours PCSTACK_CHECK_EN to pick the overflow expectations.
module tb_pcounter_stack;
  import pc_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  op;
  logic [10:0] target;
  logic        clr_flags;
  logic [10:0] counter;
  logic [3:0]  depth;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_ovf;
  logic        stack_unf;

  int checks = 0;
  int errors = 0;

  pcounter_stack #(
    .PC_W         (11),
    .STACK_DEPTH  (8),
    .RESET_VECTOR (11'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .target      (target),
    .clr_flags   (clr_flags),
    .counter     (counter),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Drive one op, let it execute on the next rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] o, input logic [10:0] t);
    op     = o;
    target = t;
    @(posedge clk);
    #1;
  endtask

  // Return address pushed by the k-th CALL of the overflow chain (starts at PC 10,
  // call k targets 100*k).
  function automatic int ret_addr(input int k);
    return (k == 1) ? 11 : 100 * (k - 1) + 1;
  endfunction

  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    op        = PC_INC;
    target    = '0;
    clr_flags = 1'b0;
    #2;
    check("rst_pc", 32'(counter), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_empty", 32'(stack_empty), 1);
    check("rst_full", 32'(stack_full), 0);
    check("rst_ovf", 32'(stack_ovf), 0);
    check("rst_unf", 32'(stack_unf), 0);
    reset = 1'b1;
    en    = 1'b1;

    // Count to 37, then pulse reset asynchronously mid-cycle.
    repeat (37) step(PC_INC, '0);
    check("count37", 32'(counter), 37);
    reset = 1'b0;
    #1;
    check("async_rst_pc", 32'(counter), 0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(PC_INC, '0);
      check("inc_after_rst", 32'(counter), 32'(i));
      check("inc_empty", 32'(stack_empty), 1);
    end

    // Modulo arithmetic at the top of the address space.
    step(PC_JUMP, 11'd2046); check("wrap_jump", 32'(counter), 2046);
    step(PC_INC, '0);        check("wrap_inc1", 32'(counter), 2047);
    step(PC_INC, '0);        check("wrap_inc0", 32'(counter), 0);
    step(PC_JUMP, 11'd2047); check("jump_top", 32'(counter), 2047);
    step(PC_SKIP, '0);       check("wrap_skip", 32'(counter), 1);
    step(PC_JUMP, 11'd2047);
    step(PC_CALL, 11'd300);  check("call_top_pc", 32'(counter), 300);
    check("call_top_depth", 32'(depth), 1);
    step(PC_RET, '0);        check("ret_top_pc", 32'(counter), 0);
    check("ret_top_depth", 32'(depth), 0);
    step(PC_SKIP, '0);       check("skip_pc", 32'(counter), 2);

    // Nested call/return.
    step(PC_JUMP, 11'd5);   check("cr_jump", 32'(counter), 5);
    step(PC_CALL, 11'd100); check("cr_call1", 32'(counter), 100);
    check("cr_d1", 32'(depth), 1);
    step(PC_INC, '0);       check("cr_inc", 32'(counter), 101);
    step(PC_CALL, 11'd200); check("cr_call2", 32'(counter), 200);
    check("cr_d2", 32'(depth), 2);
    step(PC_RET, '0);       check("cr_ret1", 32'(counter), 102);
    check("cr_d3", 32'(depth), 1);
    step(PC_RET, '0);       check("cr_ret2", 32'(counter), 6);
    check("cr_d4", 32'(depth), 0);

    // en=0 holds everything regardless of op/target.
    step(PC_CALL, 11'd400); check("hold_call", 32'(counter), 400);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(PC_JUMP, 11'd999);
      check("hold_pc", 32'(counter), 400);
      check("hold_depth", 32'(depth), 1);
    end
    en = 1'b1;
    step(PC_RET, '0);       check("hold_ret", 32'(counter), 7);
    step(3'd6, 11'd555);    check("rsvd6", 32'(counter), 8);
    step(3'd7, 11'd555);    check("rsvd7", 32'(counter), 9);
    step(PC_HOLD, 11'd555); check("hold_op", 32'(counter), 9);

    // Overflow chain: nine CALLs into an eight-deep stack.
    step(PC_JUMP, 11'd10);
    for (int k = 1; k <= 9; k++) begin
      step(PC_CALL, 11'(100 * k));
      check("ovf_call_pc", 32'(counter), 32'(100 * k));
      check("ovf_call_depth", 32'(depth), 32'((k > 8) ? 8 : k));
    end
    check("ovf_full", 32'(stack_full), 1);
`ifdef PCSTACK_CHECK_EN
    check("ovf_flag", 32'(stack_ovf), 1);
    for (int k = 8; k >= 1; k--) begin
      step(PC_RET, '0);
      check("unwind_pc", 32'(counter), 32'(ret_addr(k)));
    end
    check("unwind_empty", 32'(stack_empty), 1);
    step(PC_RET, '0);
    check("unf_pc", 32'(counter), 12);
    check("unf_depth", 32'(depth), 0);
    check("unf_flag", 32'(stack_unf), 1);
    check("ovf_sticky", 32'(stack_ovf), 1);
    clr_flags = 1'b1;
    step(PC_HOLD, '0);
    clr_flags = 1'b0;
    check("clr_ovf", 32'(stack_ovf), 0);
    check("clr_unf", 32'(stack_unf), 0);
    // Clear wins over an underflow in the same cycle.
    clr_flags = 1'b1;
    step(PC_RET, '0);
    clr_flags = 1'b0;
    check("clr_prio_pc", 32'(counter), 13);
    check("clr_prio_unf", 32'(stack_unf), 0);
`else
    check("ovf_flag", 32'(stack_ovf), 0);
    for (int k = 9; k >= 2; k--) begin
      step(PC_RET, '0);
      check("unwind_pc", 32'(counter), 32'(ret_addr(k)));
    end
    check("unwind_empty", 32'(stack_empty), 1);
    step(PC_RET, '0);
    check("wrap_slot_pc", 32'(counter), 32'(ret_addr(9)));
    check("wrap_slot_depth", 32'(depth), 0);
    check("unf_flag", 32'(stack_unf), 0);
    clr_flags = 1'b1;
    step(PC_HOLD, '0);
    clr_flags = 1'b0;
    check("clr_ovf", 32'(stack_ovf), 0);
    check("clr_unf", 32'(stack_unf), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcounter_stack.md
# pcounter_stack

Parametrised program-counter unit for the microcontroller datapath, successor to the fixed 11-bit free-running counter. It keeps the increment behaviour and adds jump, skip and call/return through an internal hardware return-address stack, with configurable address width and stack depth. It drives the `counter` address into `rom` and takes its control op from `decode` each instruction cycle.

## Interface
Parameters:
- `PC_W`, 11, program-counter width in bits (ROM address width).
- `STACK_DEPTH`, 8, number of return-address entries (≥2).
- `RESET_VECTOR`, 0, `counter` value after reset (`PC_W` bits).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Asserting it immediately forces all state to reset values; release is synchronous to `clk`.
- `en`  in  1  advance enable; 0 holds all state.
- `op`  in  3  control op, from `pc_pkg::pc_op_t`.
- `target`  in  `PC_W`  destination for JUMP/CALL.
- `clr_flags`  in  1  clears sticky error flags.
- `counter`  out  `PC_W`  current instruction address; registered.
- `depth`  out  `$clog2(STACK_DEPTH+1)`  occupied stack entries.
- `stack_full`  out  1  `depth == STACK_DEPTH`.
- `stack_empty`  out  1  `depth == 0`.
- `stack_ovf`  out  1  sticky overflow flag.
- `stack_unf`  out  1  sticky underflow flag.

## Operation
- Reset values: `counter = RESET_VECTOR`, `depth = 0`, `stack_empty = 1`, `stack_full = 0`, `stack_ovf = 0`, `stack_unf = 0`. Stack contents are don't-care after reset.
- When `en = 1`, ops execute on each rising edge:
  - INC (0): `counter <= counter + 1`.
  - JUMP (1): `counter <= target`.
  - CALL (2): push `counter + 1`, then `counter <= target`.
  - RET (3): pop the top entry into `counter`.
  - SKIP (4): `counter <= counter + 2`.
  - HOLD (5): no change.
  - Codes 6 and 7 are reserved and behave as INC.
- All PC arithmetic is modulo 2^`PC_W`:
  - INC from all-ones gives 0.
  - SKIP from all-ones gives 1.
  - The value pushed by CALL at all-ones is 0.
- `en = 0`: `counter`, stack and flags hold. `clr_flags` is still honoured.
- `clr_flags` has priority over a flag set in the same cycle: the flags read 0 on the next cycle.
- Overflow and underflow behaviour depends on the configuration macro (see Configuration).

## Timing
- `counter` updates one cycle after an op is sampled; it is valid from the clock edge onward.
- `depth`, `stack_full`, `stack_empty` and the flags are registered and update on the same edge as `counter`.
- Back-to-back ops are supported at one per cycle, including CALL immediately followed by RET. That pair returns to the call site + 1 with zero bubbles.
- `target` is only sampled when JUMP or CALL is executed.
- Reset asserted mid-call-chain discards the whole stack. The first op after reset release executes against `counter = RESET_VECTOR`.

## Configuration
- Macro `PCSTACK_CHECK_EN`.
- Defined (checked mode):
  - CALL when full: the jump is taken, the push is dropped, `depth` stays at `STACK_DEPTH`, and `stack_ovf` is set.
  - RET when empty: `counter <= counter + 1`, `depth` stays 0, and `stack_unf` is set.
- Undefined (circular mode, PIC16-compatible):
  - The stack pointer wraps modulo `STACK_DEPTH`. CALL when full overwrites the oldest entry; RET when empty pops the wrapped slot.
  - `depth` saturates at `STACK_DEPTH` and floors at 0.
  - `stack_ovf` and `stack_unf` are tied to 0 and `clr_flags` is ignored.

## Structure
- Package `pc_pkg` holds:
  - `pc_op_t`, a 3-bit enum: `PC_INC`, `PC_JUMP`, `PC_CALL`, `PC_RET`, `PC_SKIP`, `PC_HOLD`.
  - Default width constants shared with `decode` and `rom`.
- Sub-module `pc_stack_lifo` holds the return-address storage array, pointer and depth count. Its push/pop interface supports simultaneous push and pop.
- The top level holds the PC register, next-PC mux, and flag logic.

## Test plan
All scenarios use `PC_W = 11`, `STACK_DEPTH = 8`, `RESET_VECTOR = 0`.
- Reset/INC: pulse `reset` low mid-count at `counter = 37` → `counter` reads 0 immediately; it then reads 1, 2, 3 on successive edges, with `stack_empty = 1`.
- Wrap: JUMP to 2046, then INC, INC, SKIP → `counter` reads 2046, 2047, 0, 2.
- Call/return: at `counter = 5`, CALL to 100; at 101, CALL to 200; then RET, RET → `counter` reads 100, 101, 200, 102, 6. `depth` reads 1, 2, 1, 0.
- Hold: `en = 0` for 3 cycles during a CALL chain → `counter` and `depth` are unchanged; `op` is ignored.
- Overflow (checked mode): 9 CALLs → `depth = 8`, `stack_full = 1`, `stack_ovf = 1`. Eight RETs then unwind entries 8 down to 1, ninth-call target excluded. A ninth RET sets `stack_unf = 1` and INCs. `clr_flags` then clears both flags next cycle.
- Overflow (circular mode, macro undefined): 9 CALLs → the oldest return address is replaced; 8 RETs yield returns 9 down to 2, then the wrapped slot; the flags stay 0.
